cp0_exc_ctrl: RTL and testbench

//  CP0 exception sequencer, directly downstream of the exception decode unit in the CP0 block.
//  - Takes the one-hot exception flags from exc_decode plus the faulting context.
//  - Prioritises the flags and records EPC, BadVAddr, Cause and Status.EXL/ERL.
//  - Runs a flush/redirect sequence that steers the fetch PC to the handler vector.
//  - Handles ERET return and blocks further pipeline traffic while a sequence is active.

---
 rtl/cp0_exc_ctrl_pkg.sv | 76 +++++++
 rtl/cp0_exc_ctrl_prio_enc.sv | 54 +++++
 rtl/cp0_exc_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl_pkg
//   Shared definitions for the CP0 exception sequencer:
//     - sequencer FSM state encoding (2-bit)
//     - MIPS Cause.ExcCode constants
//     - default handler vectors and flush length
//     - bit positions of the decoded exception flags, in priority order
//       (index 0 is the highest priority)
//     - helpers: flag -> ExcCode mapping, restart PC for delay slots
// ---------------------------------------------------------------------------
package cp0_exc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_t;

    // MIPS Cause.ExcCode values
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_IBE  = 5'd6;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    // Default vectors and flush length
    localparam logic [31:0] DEF_EXC_VEC      = 32'hBFC0_0380;
    localparam logic [31:0] DEF_CACHE_VEC    = 32'hBFC0_0300;
    localparam int          DEF_FLUSH_CYCLES = 3;

    // Flag bit positions; lower index wins
    localparam int EXC_FLAG_NUM   = 12;
    localparam int FI_ADDR_F      = 0;
    localparam int FI_CACHE_F     = 1;
    localparam int FI_BUS_F       = 2;
    localparam int FI_CP0_UNUSED  = 3;
    localparam int FI_INSTR_UNDEF = 4;
    localparam int FI_OVERFLOW    = 5;
    localparam int FI_TRAP        = 6;
    localparam int FI_SYSCALL     = 7;
    localparam int FI_BREAK       = 8;
    localparam int FI_ADDR_M      = 9;
    localparam int FI_CACHE_M     = 10;
    localparam int FI_BUS_M       = 11;

    // ExcCode for a given flag position. Cache errors have no ExcCode
    // (they go to ErrorEPC and leave Cause alone), so they map to 0.
    function automatic logic [4:0] flag_exccode(input int idx, input logic store);
        logic [4:0] code;
        case (idx)
            FI_ADDR_F:      code = EXC_ADEL;
            FI_BUS_F:       code = EXC_IBE;
            FI_CP0_UNUSED:  code = EXC_CPU;
            FI_INSTR_UNDEF: code = EXC_RI;
            FI_OVERFLOW:    code = EXC_OV;
            FI_TRAP:        code = EXC_TR;
            FI_SYSCALL:     code = EXC_SYS;
            FI_BREAK:       code = EXC_BP;
            FI_ADDR_M:      code = store ? EXC_ADES : EXC_ADEL;
            FI_BUS_M:       code = EXC_DBE;
            default:        code = 5'd0;
        endcase
        return code;
    endfunction

    // Restart address: a faulting delay-slot instruction restarts at its branch.
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_prio_enc.sv
// ---------------------------------------------------------------------------
// exc_prio_enc
//   Combinational priority encoder for the decoded exception flags.
//   Ports:
//     flags      in  12  decoded flags, bit 0 = highest priority
//     exc_store  in  1   M-stage access was a store (selects AdES)
//     exccode    out 5   ExcCode of the winning flag (0 for cache errors)
//     is_cache   out 1   winning flag is a cache error (F or M stage)
//     is_addr_f  out 1   winning flag is the fetch address error
//     hit        out 1   at least one flag is set
// ---------------------------------------------------------------------------
module exc_prio_enc
    import cp0_exc_ctrl_pkg::*;
(
    input  logic [EXC_FLAG_NUM-1:0] flags,
    input  logic                    exc_store,
    output logic [4:0]              exccode,
    output logic                    is_cache,
    output logic                    is_addr_f,
    output logic                    hit
);

    // above[i] is set when any flag of higher priority than i is set;
    // win is then the one-hot winner.
    logic [EXC_FLAG_NUM-1:0] above;
    logic [EXC_FLAG_NUM-1:0] win;

    assign above[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < EXC_FLAG_NUM; gi++) begin : g_chain
            assign above[gi] = above[gi-1] | flags[gi-1];
        end
        for (gi = 0; gi < EXC_FLAG_NUM; gi++) begin : g_win
            assign win[gi] = flags[gi] & ~above[gi];
        end
    endgenerate

    // win is one-hot, so OR-ing the selected codes yields the winner's code
    always_comb begin
        exccode = 5'd0;
        for (int i = 0; i < EXC_FLAG_NUM; i++) begin
            if (win[i]) begin
                exccode = exccode | flag_exccode(i, exc_store);
            end
        end
    end

    assign is_cache  = win[FI_CACHE_F] | win[FI_CACHE_M];
    assign is_addr_f = win[FI_ADDR_F];
    assign hit       = |flags;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
//   CP0 exception sequencer. Accepts prioritised exceptions and ERET from the
//   pipeline, updates EPC/ErrorEPC/BadVAddr/Cause/Status, then runs a
//   FLUSH (FLUSH_CYCLES cycles) -> REDIRECT (1 cycle) sequence steering fetch
//   to the handler vector or the return address.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     exc_valid + 12 flags         exception presented by exc_decode
//     exc_store, exc_pc, exc_bd,
//     exc_badvaddr                 faulting context
//     eret                         ERET committing
//     epc_we, epc_wdata            MTC0 write to EPC
//     busy, flush                  pipeline stall / kill
//     redirect_valid, redirect_pc  one-cycle fetch redirect
//     epc, errorepc, badvaddr,
//     cause_exccode, cause_bd,
//     status_exl, status_erl       CP0 register state
// ---------------------------------------------------------------------------
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC      = DEF_EXC_VEC,
    parameter logic [31:0] CACHE_VEC    = DEF_CACHE_VEC,
    parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic        addr_err_f,
    input  logic        cache_err_f,
    input  logic        bus_err_f,
    input  logic        cp0_unused,
    input  logic        instr_undefine,
    input  logic        overflow,
    input  logic        trap,
    input  logic        syscall,
    input  logic        break_point,
    input  logic        addr_err_m,
    input  logic        cache_err_m,
    input  logic        bus_err_m,
    input  logic        exc_store,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic        epc_we,
    input  logic [31:0] epc_wdata,
    output logic        busy,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [31:0] errorepc,
    output logic [31:0] badvaddr,
    output logic [4:0]  cause_exccode,
    output logic        cause_bd,
    output logic        status_exl,
    output logic        status_erl
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    // ------------------------------------------------------------------
    // Flag vector in priority order and encoder
    // ------------------------------------------------------------------
    logic [EXC_FLAG_NUM-1:0] flags;
    logic [4:0]              enc_code;
    logic                    enc_is_cache;
    logic                    enc_is_addr_f;
    logic                    enc_hit;

    assign flags[FI_ADDR_F]      = addr_err_f;
    assign flags[FI_CACHE_F]     = cache_err_f;
    assign flags[FI_BUS_F]       = bus_err_f;
    assign flags[FI_CP0_UNUSED]  = cp0_unused;
    assign flags[FI_INSTR_UNDEF] = instr_undefine;
    assign flags[FI_OVERFLOW]    = overflow;
    assign flags[FI_TRAP]        = trap;
    assign flags[FI_SYSCALL]     = syscall;
    assign flags[FI_BREAK]       = break_point;
    assign flags[FI_ADDR_M]      = addr_err_m;
    assign flags[FI_CACHE_M]     = cache_err_m;
    assign flags[FI_BUS_M]       = bus_err_m;

    exc_prio_enc u_prio_enc (
        .flags     (flags),
        .exc_store (exc_store),
        .exccode   (enc_code),
        .is_cache  (enc_is_cache),
        .is_addr_f (enc_is_addr_f),
        .hit       (enc_hit)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    exc_state_t  state_reg,    state_next;
    logic [3:0]  cnt_reg,      cnt_next;
    logic [31:0] target_reg,   target_next;
    logic [31:0] epc_reg,      epc_next;
    logic [31:0] errorepc_reg, errorepc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic [4:0]  exccode_reg,  exccode_next;
    logic        bd_reg,       bd_next;
    logic        exl_reg,      exl_next;
    logic        erl_reg,      erl_next;

    logic        exc_take;
    logic        eret_take;
    logic        is_addr;

    // Requests are only honoured in IDLE; exception beats a same-cycle ERET.
    // A flag-less exc_valid is not an event at all.
    assign exc_take  = (state_reg == ST_IDLE) && exc_valid && enc_hit;
    assign eret_take = (state_reg == ST_IDLE) && eret && !exc_take;

    // Only AdEL/AdES carry those codes, so this singles out address errors
    assign is_addr = !enc_is_cache && ((enc_code == EXC_ADEL) || (enc_code == EXC_ADES));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        target_next   = target_reg;
        epc_next      = epc_reg;
        errorepc_next = errorepc_reg;
        badvaddr_next = badvaddr_reg;
        exccode_next  = exccode_reg;
        bd_next       = bd_reg;
        exl_next      = exl_reg;
        erl_next      = erl_reg;

        case (state_reg)
            ST_IDLE: begin
                if (exc_take) begin
                    if (enc_is_cache) begin
                        errorepc_next = restart_pc(exc_pc, exc_bd);
                        erl_next      = 1'b1;
                        target_next   = CACHE_VEC;
                    end else begin
                        exccode_next = enc_code;
                        exl_next     = 1'b1;
                        // Nested exception keeps the original EPC/BD so the
                        // outer handler can still return correctly.
                        if (!exl_reg) begin
                            epc_next = restart_pc(exc_pc, exc_bd);
                            bd_next  = exc_bd;
                        end
                        if (is_addr) begin
                            badvaddr_next = enc_is_addr_f ? exc_pc : exc_badvaddr;
                        end
                        target_next = EXC_VEC;
                    end
                    cnt_next   = FLUSH_INIT;
                    state_next = ST_FLUSH;
                end else begin
                    if (eret_take) begin
                        if (erl_reg) begin
                            target_next = errorepc_reg;
                            erl_next    = 1'b0;
                        end else begin
                            target_next = epc_reg;
                            exl_next    = 1'b0;
                        end
                        cnt_next   = FLUSH_INIT;
                        state_next = ST_FLUSH;
                    end
                    if (epc_we) begin
                        epc_next = epc_wdata;
                    end
                end
            end

            ST_FLUSH: begin
                if (cnt_reg <= 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = ST_REDIRECT;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end

            ST_REDIRECT: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            target_reg   <= 32'd0;
            epc_reg      <= 32'd0;
            errorepc_reg <= 32'd0;
            badvaddr_reg <= 32'd0;
            exccode_reg  <= 5'd0;
            bd_reg       <= 1'b0;
            exl_reg      <= 1'b0;
            erl_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            target_reg   <= target_next;
            epc_reg      <= epc_next;
            errorepc_reg <= errorepc_next;
            badvaddr_reg <= badvaddr_next;
            exccode_reg  <= exccode_next;
            bd_reg       <= bd_next;
            exl_reg      <= exl_next;
            erl_reg      <= erl_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy           = (state_reg != ST_IDLE);
    assign flush          = (state_reg == ST_FLUSH);
    assign redirect_valid = (state_reg == ST_REDIRECT);
    assign redirect_pc    = redirect_valid ? target_reg : 32'd0;
    assign epc            = epc_reg;
    assign errorepc       = errorepc_reg;
    assign badvaddr       = badvaddr_reg;
    assign cause_exccode  = exccode_reg;
    assign cause_bd       = bd_reg;
    assign status_exl     = exl_reg;
    assign status_erl     = erl_reg;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//   Directed bench for cp0_exc_ctrl: a table of hand-computed transactions
//   applied in order (register state carries from one row to the next),
//   followed by hand-written sequences for requests during a busy sequence
//   and reset in the middle of a flush.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

    localparam logic [31:0] EXC  = 32'hBFC0_0380;
    localparam logic [31:0] CACH = 32'hBFC0_0300;

    // flag bits, bit 0 = highest priority
    localparam logic [11:0] F_AF  = 12'h001;
    localparam logic [11:0] F_CF  = 12'h002;
    localparam logic [11:0] F_BF  = 12'h004;
    localparam logic [11:0] F_CPU = 12'h008;
    localparam logic [11:0] F_RI  = 12'h010;
    localparam logic [11:0] F_OV  = 12'h020;
    localparam logic [11:0] F_TR  = 12'h040;
    localparam logic [11:0] F_SYS = 12'h080;
    localparam logic [11:0] F_BP  = 12'h100;
    localparam logic [11:0] F_AM  = 12'h200;
    localparam logic [11:0] F_CM  = 12'h400;
    localparam logic [11:0] F_BM  = 12'h800;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [11:0] fl;
    logic        exc_store;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        epc_we;
    logic [31:0] epc_wdata;
    logic        busy, flush, redirect_valid;
    logic [31:0] redirect_pc, epc, errorepc, badvaddr;
    logic [4:0]  cause_exccode;
    logic        cause_bd, status_exl, status_erl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .addr_err_f     (fl[0]),
        .cache_err_f    (fl[1]),
        .bus_err_f      (fl[2]),
        .cp0_unused     (fl[3]),
        .instr_undefine (fl[4]),
        .overflow       (fl[5]),
        .trap           (fl[6]),
        .syscall        (fl[7]),
        .break_point    (fl[8]),
        .addr_err_m     (fl[9]),
        .cache_err_m    (fl[10]),
        .bus_err_m      (fl[11]),
        .exc_store      (exc_store),
        .exc_pc         (exc_pc),
        .exc_bd         (exc_bd),
        .exc_badvaddr   (exc_badvaddr),
        .eret           (eret),
        .epc_we         (epc_we),
        .epc_wdata      (epc_wdata),
        .busy           (busy),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .errorepc       (errorepc),
        .badvaddr       (badvaddr),
        .cause_exccode  (cause_exccode),
        .cause_bd       (cause_bd),
        .status_exl     (status_exl),
        .status_erl     (status_erl)
    );

    typedef struct packed {
        logic        ev;
        logic [11:0] fl;
        logic        st;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] bva;
        logic        er;
        logic        we;
        logic [31:0] wd;
        logic        seq;   // a flush/redirect sequence is expected
        logic [4:0]  code;
        logic        ebd;
        logic        exl;
        logic        erl;
        logic [31:0] epc;
        logic [31:0] eepc;
        logic [31:0] ebva;
        logic [31:0] tgt;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    function automatic vec_t mk(input logic ev, input logic [11:0] f, input logic st,
                                input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                                input logic er, input logic we, input logic [31:0] wd,
                                input logic seq, input logic [4:0] code, input logic ebd,
                                input logic exl, input logic erl, input logic [31:0] e_epc,
                                input logic [31:0] e_eepc, input logic [31:0] e_bva,
                                input logic [31:0] tgt);
        vec_t v;
        v.ev = ev; v.fl = f; v.st = st; v.pc = pc; v.bd = bd; v.bva = bva;
        v.er = er; v.we = we; v.wd = wd; v.seq = seq; v.code = code; v.ebd = ebd;
        v.exl = exl; v.erl = erl; v.epc = e_epc; v.eepc = e_eepc; v.ebva = e_bva; v.tgt = tgt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        exc_valid = 1'b0; fl = 12'h0; exc_store = 1'b0; exc_pc = 32'h0; exc_bd = 1'b0;
        exc_badvaddr = 32'h0; eret = 1'b0; epc_we = 1'b0; epc_wdata = 32'h0;
    endtask

    task automatic check_regs(input string p, input vec_t v);
        chk({p, ".exccode"},  {27'd0, cause_exccode}, {27'd0, v.code});
        chk({p, ".bd"},       {31'd0, cause_bd},      {31'd0, v.ebd});
        chk({p, ".exl"},      {31'd0, status_exl},    {31'd0, v.exl});
        chk({p, ".erl"},      {31'd0, status_erl},    {31'd0, v.erl});
        chk({p, ".epc"},      epc,      v.epc);
        chk({p, ".errorepc"}, errorepc, v.eepc);
        chk({p, ".badvaddr"}, badvaddr, v.ebva);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        int    n;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        exc_valid = v.ev; fl = v.fl; exc_store = v.st; exc_pc = v.pc; exc_bd = v.bd;
        exc_badvaddr = v.bva; eret = v.er; epc_we = v.we; epc_wdata = v.wd;
        @(posedge clk);
        #1 idle_in();
        @(negedge clk);
        check_regs(p, v);
        n = 0;
        if (v.seq) begin
            chk({p, ".busy"}, {31'd0, busy}, 32'd1);
            while (flush === 1'b1 && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk({p, ".flush_len"}, n, 32'd3);
            chk({p, ".redir_v"},   {31'd0, redirect_valid}, 32'd1);
            chk({p, ".redir_pc"},  redirect_pc, v.tgt);
            @(negedge clk);
            chk({p, ".busy_end"},  {31'd0, busy}, 32'd0);
            chk({p, ".redir_end"}, {31'd0, redirect_valid}, 32'd0);
        end else begin
            chk({p, ".busy"}, {31'd0, busy}, 32'd0);
        end
        $display("txn %0d: ev=%0b flags=%h eret=%0b we=%0b code=%0d epc=%h flush_len=%0d redirect=%h",
                 idx, v.ev, v.fl, v.er, v.we, cause_exccode, epc, n, v.tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        //        ev  flags        st  pc            bd  bva           er  we  wd            seq code   ebd exl erl epc           errorepc      badvaddr      target
        vt[0]  = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd0,  0,  0,  0, 32'h0,        32'h0,    32'h0,        32'h0);
        vt[1]  = mk(0, F_OV,       0, 32'h1111,     0, 32'h0,        0,  0, 32'h0,        0, 5'd0,  0,  0,  0, 32'h0,        32'h0,    32'h0,        32'h0);
        vt[2]  = mk(1, F_OV,       0, 32'h1000,     0, 32'h0,        0,  0, 32'h0,        1, 5'd12, 0,  1,  0, 32'h1000,     32'h0,    32'h0,        EXC);
        vt[3]  = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd12, 0,  0,  0, 32'h1000,     32'h0,    32'h0,        32'h1000);
        vt[4]  = mk(1, F_SYS,      0, 32'h2004,     1, 32'h0,        0,  0, 32'h0,        1, 5'd8,  1,  1,  0, 32'h2000,     32'h0,    32'h0,        EXC);
        vt[5]  = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd8,  1,  0,  0, 32'h2000,     32'h0,    32'h0,        32'h2000);
        vt[6]  = mk(1, F_AM,       1, 32'h2100,     0, 32'h80000003, 0,  0, 32'h0,        1, 5'd5,  0,  1,  0, 32'h2100,     32'h0,    32'h80000003, EXC);
        vt[7]  = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd5,  0,  0,  0, 32'h2100,     32'h0,    32'h80000003, 32'h2100);
        vt[8]  = mk(1, F_OV|F_SYS, 0, 32'h2200,     0, 32'h0,        0,  0, 32'h0,        1, 5'd12, 0,  1,  0, 32'h2200,     32'h0,    32'h80000003, EXC);
        vt[9]  = mk(1, F_TR,       0, 32'h2300,     1, 32'h0,        0,  0, 32'h0,        1, 5'd13, 0,  1,  0, 32'h2200,     32'h0,    32'h80000003, EXC);
        vt[10] = mk(1, F_AF,       0, 32'h2404,     0, 32'h1,        0,  0, 32'h0,        1, 5'd4,  0,  1,  0, 32'h2200,     32'h0,    32'h2404,     EXC);
        vt[11] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd4,  0,  0,  0, 32'h2200,     32'h0,    32'h2404,     32'h2200);
        vt[12] = mk(1, F_BP,       0, 32'h5000,     0, 32'h0,        0,  0, 32'h0,        1, 5'd9,  0,  1,  0, 32'h5000,     32'h0,    32'h2404,     EXC);
        vt[13] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        0,  1, 32'h3000,     0, 5'd9,  0,  1,  0, 32'h3000,     32'h0,    32'h2404,     32'h0);
        vt[14] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd9,  0,  0,  0, 32'h3000,     32'h0,    32'h2404,     32'h3000);
        vt[15] = mk(1, F_RI,       0, 32'h6000,     0, 32'h0,        1,  0, 32'h0,        1, 5'd10, 0,  1,  0, 32'h6000,     32'h0,    32'h2404,     EXC);
        vt[16] = mk(1, F_CF,       0, 32'h4000,     0, 32'h0,        0,  0, 32'h0,        1, 5'd10, 0,  1,  1, 32'h6000,     32'h4000, 32'h2404,     CACH);
        vt[17] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd10, 0,  1,  0, 32'h6000,     32'h4000, 32'h2404,     32'h4000);
        vt[18] = mk(1, F_CPU,      0, 32'h7000,     0, 32'h0,        0,  0, 32'h0,        1, 5'd11, 0,  1,  0, 32'h6000,     32'h4000, 32'h2404,     EXC);
        vt[19] = mk(1, 12'h0,      0, 32'h7004,     0, 32'h0,        0,  1, 32'h1234,     0, 5'd11, 0,  1,  0, 32'h1234,     32'h4000, 32'h2404,     32'h0);
        vt[20] = mk(1, F_AM|F_BM,  0, 32'h7100,     0, 32'h90000000, 0,  1, 32'hDEAD,     1, 5'd4,  0,  1,  0, 32'h1234,     32'h4000, 32'h90000000, EXC);
        vt[21] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd4,  0,  0,  0, 32'h1234,     32'h4000, 32'h90000000, 32'h1234);
        vt[22] = mk(1, F_BF,       0, 32'h8000,     1, 32'h0,        0,  0, 32'h0,        1, 5'd6,  1,  1,  0, 32'h7FFC,     32'h4000, 32'h90000000, EXC);
        vt[23] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd6,  1,  0,  0, 32'h7FFC,     32'h4000, 32'h90000000, 32'h7FFC);
        vt[24] = mk(1, F_BM,       0, 32'h8100,     0, 32'h0,        0,  0, 32'h0,        1, 5'd7,  0,  1,  0, 32'h8100,     32'h4000, 32'h90000000, EXC);
        vt[25] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd7,  0,  0,  0, 32'h8100,     32'h4000, 32'h90000000, 32'h8100);
        vt[26] = mk(1, F_CM,       0, 32'h9004,     1, 32'h0,        0,  0, 32'h0,        1, 5'd7,  0,  0,  1, 32'h8100,     32'h9000, 32'h90000000, CACH);
        vt[27] = mk(0, 12'h0,      0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 5'd7,  0,  0,  0, 32'h8100,     32'h9000, 32'h90000000, 32'h9000);
        vt[28] = mk(1, F_AF,       0, 32'h0,        1, 32'h0,        0,  0, 32'h0,        1, 5'd4,  1,  1,  0, 32'hFFFFFFFC, 32'h9000, 32'h0,        EXC);

        idle_in();
        rst = 1'b1;
        #12;
        chk("rst.busy",     {31'd0, busy},           32'd0);
        chk("rst.flush",    {31'd0, flush},          32'd0);
        chk("rst.redir_v",  {31'd0, redirect_valid}, 32'd0);
        chk("rst.redir_pc", redirect_pc,             32'd0);
        chk("rst.epc",      epc,                     32'd0);
        chk("rst.errorepc", errorepc,                32'd0);
        chk("rst.badvaddr", badvaddr,                32'd0);
        chk("rst.exccode",  {27'd0, cause_exccode},  32'd0);
        chk("rst.bd",       {31'd0, cause_bd},       32'd0);
        chk("rst.exl",      {31'd0, status_exl},     32'd0);
        chk("rst.erl",      {31'd0, status_erl},     32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vt[i]);
        end

        // Requests while busy are ignored: nested overflow, then syscall /
        // eret / EPC write held during the flush.
        @(negedge clk);
        exc_valid = 1'b1; fl = F_OV; exc_pc = 32'hA000;
        @(posedge clk);
        #1 idle_in();
        @(negedge clk);
        chk("busy_ign.flush", {31'd0, flush}, 32'd1);
        exc_valid = 1'b1; fl = F_SYS; exc_pc = 32'hB000; eret = 1'b1;
        epc_we = 1'b1; epc_wdata = 32'h5555;
        repeat (2) @(negedge clk);
        idle_in();
        n = 0;
        while (redirect_valid !== 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("busy_ign.redir_v",  {31'd0, redirect_valid}, 32'd1);
        chk("busy_ign.redir_pc", redirect_pc,             EXC);
        chk("busy_ign.exccode",  {27'd0, cause_exccode},  32'd12);
        chk("busy_ign.epc",      epc,                     32'hFFFFFFFC);
        chk("busy_ign.exl",      {31'd0, status_exl},     32'd1);
        @(negedge clk);
        chk("busy_ign.idle",     {31'd0, busy},           32'd0);
        $display("txn busy_ignore: exccode=%0d epc=%h", cause_exccode, epc);

        // Reset in the middle of an ERET flush: immediate return to reset
        // values and no redirect afterwards.
        @(negedge clk);
        eret = 1'b1;
        @(posedge clk);
        #1 idle_in();
        @(negedge clk);
        chk("rst_mid.flush_before", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid.flush", {31'd0, flush},       32'd0);
        chk("rst_mid.busy",  {31'd0, busy},        32'd0);
        chk("rst_mid.erl",   {31'd0, status_erl},  32'd1);
        chk("rst_mid.exl",   {31'd0, status_exl},  32'd0);
        chk("rst_mid.epc",   epc,                  32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (redirect_valid === 1'b1 || busy === 1'b1) seen++;
        end
        chk("rst_mid.no_redirect", seen, 32'd0);
        $display("txn rst_mid_flush: activity_after_reset=%0d", seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
